// File: rtl/msdff_write_arbiter_if.sv
// Write-port bundle between the three requesters and the arbiter.
// Requester side is the master, the arbiter is the slave.
interface msdff_write_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic             req2;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             grant0;
  logic             grant1;
  logic             grant2;
  logic [WIDTH-1:0] Q;
  logic [1:0]       owner;
  logic             busy;

  modport master (
    output req0, req1, req2,
    output d0, d1, d2,
    input  grant0, grant1, grant2,
    input  Q, owner, busy
  );

  modport slave (
    input  req0, req1, req2,
    input  d0, d1, d2,
    output grant0, grant1, grant2,
    output Q, owner, busy
  );
endinterface

// File: rtl/msdff_write_arbiter.sv
// Round-robin write arbiter for a shared flip-flop register bank.
// One grant per write, then a fixed hold window before re-arbitration.
module msdff_write_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 Reset,
  msdff_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_INIT =
    (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       owner_q, owner_d;

  logic [2:0]       req;
  logic [1:0]       c0, c1, c2;
  logic [1:0]       win;
  logic             hit;
  logic [WIDTH-1:0] d_sel;
  logic             wr_ok;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req = {bus.req2, bus.req1, bus.req0};

  // Search order ptr, ptr+1, ptr+2 (mod 3); first asserted wins.
  always_comb begin
    c0 = ptr_q;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (req[c0])      win = c0;
    else if (req[c1]) win = c1;
    else              win = c2;
  end

  always_comb begin
    hit   = 1'b0;
    d_sel = '0;
    unique case (sel_q)
      2'd0: begin
        hit   = bus.req0;
        d_sel = bus.d0;
      end
      2'd1: begin
        hit   = bus.req1;
        d_sel = bus.d1;
      end
      default: begin
        hit   = bus.req2;
        d_sel = bus.d2;
      end
    endcase
  end

  // A requester that drops req during WRITE withdraws; no grant.
  assign wr_ok = (state_q == S_WRITE) && hit && !Reset;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    owner_d = owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          sel_d   = win;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (hit) begin
          q_d     = d_sel;
          owner_d = sel_q;
          ptr_d   = inc3(sel_q);
          if (HOLD_CYCLES > 0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      q_q     <= '0;
      owner_q <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant0 = wr_ok && (sel_q == 2'd0);
  assign bus.grant1 = wr_ok && (sel_q == 2'd1);
  assign bus.grant2 = wr_ok && (sel_q == 2'd2);
  assign bus.Q      = q_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_msdff_write_arbiter.sv
// Directed bench for msdff_write_arbiter.
// Instance a uses HOLD_CYCLES=2, instance b uses HOLD_CYCLES=0.
module tb_msdff_write_arbiter;

  logic clock = 1'b0;
  logic Reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   done  = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  msdff_write_arbiter_if #(.WIDTH(8)) a ();
  msdff_write_arbiter_if #(.WIDTH(8)) b ();

  msdff_write_arbiter #(.WIDTH(8), .HOLD_CYCLES(2)) u_a (
    .clock (clock),
    .Reset (Reset),
    .bus   (a)
  );

  msdff_write_arbiter #(.WIDTH(8), .HOLD_CYCLES(0)) u_b (
    .clock (clock),
    .Reset (Reset),
    .bus   (b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (a.grant0 | a.grant1 | a.grant2) begin
        who = a.grant0 ? 0 : (a.grant1 ? 1 : 2);
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clock) begin
    if (!done) begin
      chk("onehot_a", 32'($countones({a.grant2, a.grant1, a.grant0}) <= 1), 32'd1);
    end
  end

  initial begin : stim
    int who;
    int last;
    int gcnt;
    int bcnt;
    bit prev;
    logic [7:0] dat [3];
    dat[0] = 8'h11;
    dat[1] = 8'h22;
    dat[2] = 8'h33;

    // reset with random stimulus
    a.req0 = 1'($urandom); a.req1 = 1'($urandom); a.req2 = 1'($urandom);
    a.d0 = 8'($urandom); a.d1 = 8'($urandom); a.d2 = 8'($urandom);
    b.req0 = 1'b0; b.req1 = 1'b0; b.req2 = 1'b0;
    b.d0 = 8'h00; b.d1 = 8'h00; b.d2 = 8'h00;
    Reset = 1'b1;
    step();
    step();
    chk("rst_q", 32'(a.Q), 32'h00);
    chk("rst_owner", 32'(a.owner), 32'd0);
    chk("rst_grants", 32'({a.grant2, a.grant1, a.grant0}), 32'd0);
    chk("rst_busy", 32'(a.busy), 32'd0);

    // fairness, all requesters held high
    a.req0 = 1'b1; a.req1 = 1'b1; a.req2 = 1'b1;
    a.d0 = 8'h11; a.d1 = 8'h22; a.d2 = 8'h33;
    Reset = 1'b0;
    wait_grant(who);
    chk("first_grant", 32'(who), 32'd0);
    chk("first_busy", 32'(a.busy), 32'd1);
    last = cyc;
    for (int i = 1; i < 6; i++) begin
      step();
      chk("rr_q", 32'(a.Q), 32'(dat[(i - 1) % 3]));
      chk("rr_owner", 32'(a.owner), 32'((i - 1) % 3));
      wait_grant(who);
      chk("rr_who", 32'(who), 32'(i % 3));
      chk("rr_space", 32'(cyc - last), 32'd4);
      last = cyc;
    end
    step();
    chk("rr_q_last", 32'(a.Q), 32'h33);
    a.req0 = 1'b0; a.req1 = 1'b0; a.req2 = 1'b0;
    step();
    step();
    chk("rr_idle", 32'(a.busy), 32'd0);

    // single write from requester 1
    a.req1 = 1'b1;
    a.d1   = 8'hA5;
    gcnt = 0;
    bcnt = 0;
    prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (prev) begin
        chk("sw_q", 32'(a.Q), 32'hA5);
        chk("sw_owner", 32'(a.owner), 32'd1);
        a.req1 = 1'b0;
        a.d1   = 8'hFF;
      end
      prev = a.grant1;
      gcnt += int'(a.grant1);
      bcnt += int'(a.busy);
    end
    chk("sw_gcnt", 32'(gcnt), 32'd1);
    chk("sw_bcnt", 32'(bcnt), 32'd3);
    chk("sw_q_stable", 32'(a.Q), 32'hA5);

    // withdrawal during WRITE
    a.req0 = 1'b1;
    a.d0   = 8'h77;
    step();
    a.req0 = 1'b0;
    #1;
    chk("wd_nogrant", 32'({a.grant2, a.grant1, a.grant0}), 32'd0);
    chk("wd_busy", 32'(a.busy), 32'd1);
    step();
    chk("wd_idle", 32'(a.busy), 32'd0);
    chk("wd_q", 32'(a.Q), 32'hA5);
    chk("wd_owner", 32'(a.owner), 32'd1);
    a.req0 = 1'b1; a.req1 = 1'b1;
    a.d0 = 8'h77; a.d1 = 8'h99;
    step();
    chk("wd_regrant0", 32'(a.grant0), 32'd1);
    chk("wd_nogrant1", 32'(a.grant1), 32'd0);
    step();
    chk("wd_q2", 32'(a.Q), 32'h77);
    chk("wd_owner2", 32'(a.owner), 32'd0);
    a.req0 = 1'b0; a.req1 = 1'b0;
    step();
    step();
    chk("wd_idle2", 32'(a.busy), 32'd0);

    // HOLD_CYCLES = 0 instance
    b.req2 = 1'b1;
    b.d2   = 8'h5C;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("h0_grant", 32'(b.grant2), 32'(k % 2 == 0));
      chk("h0_busy", 32'(b.busy), 32'(k % 2 == 0));
    end
    b.req2 = 1'b0;
    chk("h0_q", 32'(b.Q), 32'h5C);
    chk("h0_owner", 32'(b.owner), 32'd2);

    // reset during WRITE
    a.req2 = 1'b1;
    a.d2   = 8'hFF;
    step();
    chk("rw_grant", 32'(a.grant2), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rw_gated", 32'(a.grant2), 32'd0);
    step();
    chk("rw_q", 32'(a.Q), 32'h00);
    chk("rw_owner", 32'(a.owner), 32'd0);
    chk("rw_busy", 32'(a.busy), 32'd0);
    chk("rw_grants", 32'({a.grant2, a.grant1, a.grant0}), 32'd0);
    a.req2 = 1'b0;
    Reset  = 1'b0;

    // reset during HOLD
    step();
    a.req1 = 1'b1;
    a.d1   = 8'h3C;
    step();
    chk("rh_grant", 32'(a.grant1), 32'd1);
    step();
    chk("rh_q_pre", 32'(a.Q), 32'h3C);
    chk("rh_busy_pre", 32'(a.busy), 32'd1);
    a.req1 = 1'b0;
    Reset  = 1'b1;
    step();
    chk("rh_q", 32'(a.Q), 32'h00);
    chk("rh_owner", 32'(a.owner), 32'd0);
    chk("rh_busy", 32'(a.busy), 32'd0);
    Reset = 1'b0;
    a.req1 = 1'b1; a.req2 = 1'b1;
    a.d1 = 8'h44; a.d2 = 8'h55;
    step();
    chk("rh_ptr_g1", 32'(a.grant1), 32'd1);
    chk("rh_ptr_g2", 32'(a.grant2), 32'd0);
    step();
    chk("rh_q_post", 32'(a.Q), 32'h44);
    a.req1 = 1'b0; a.req2 = 1'b0;

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
